// File: rtl/felica_pkg.sv
// Shared definitions for the FeliCa 212 kbit/s receive path: FSM states,
// framing constants and the serial CRC-16 step used by deframer and modulator.
package felica_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_SYNC,
    ST_LEN,
    ST_DATA,
    ST_CRC
  } state_t;

  localparam logic [15:0] FELICA_SYNC = 16'hB24D;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_INIT    = 16'h0000;
  localparam int          LEN_MIN     = 2;

  // One MSB-first bit of CRC-16; running it over data plus appended CRC leaves 0.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/felica_crc16.sv
// Serial CRC-16 register (poly 0x1021). clear has priority over en.
module felica_crc16
  import felica_pkg::*;
(
  input  logic        ck_1356meg,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/felica_deframer.sv
// Bit-to-byte deframer: hunts preamble + SYNC, emits LEN/payload/CRC bytes
// with frame markers and a CRC verdict on the last byte.
module felica_deframer
  import felica_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD    = FELICA_SYNC,
  parameter int          MIN_PREAMBLE = 16
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       carrier_lost,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       crc_ok,
  output logic       frame_err
);

  state_t      state;
  logic [5:0]  zero_run;
  logic [3:0]  sync_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [7:0]  len_rem;
  logic        crc_second;
  logic [15:0] crc;

  logic        in_frame;
  logic        take_bit;
  logic        sync_bit;
  logic [7:0]  byte_next;
  logic [15:0] crc_final;
  logic        crc_clear;
  logic        crc_en;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_frame  = 1'b0;
    sync_bit  = SYNC_WORD[4'd15 - sync_cnt];
    byte_next = {shreg, bit_in};
    crc_final = crc16_step(crc, bit_in);
    if (state == ST_LEN || state == ST_DATA || state == ST_CRC) in_frame = 1'b1;
    // enable low and carrier loss both override (and discard) a bit strobe
    take_bit  = enable && !carrier_lost && bit_valid;
    crc_clear = take_bit && (state == ST_SYNC) && (bit_in == sync_bit) && (sync_cnt == 4'd15);
    crc_en    = take_bit && in_frame;
  end

  felica_crc16 u_crc (
    .ck_1356meg (ck_1356meg),
    .rst_n      (rst_n),
    .clear      (crc_clear),
    .en         (crc_en),
    .din        (bit_in),
    .crc        (crc)
  );

  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HUNT;
      zero_run    <= '0;
      sync_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      len_rem     <= '0;
      crc_second  <= 1'b0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      crc_ok      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      if (!enable) begin
        state    <= ST_HUNT;
        zero_run <= '0;
      end else if (carrier_lost) begin
        if (in_frame) begin
          frame_end <= 1'b1;
          frame_err <= 1'b1;
          crc_ok    <= 1'b0;
        end
        state    <= ST_HUNT;
        zero_run <= '0;
      end else if (bit_valid) begin
        case (state)
          ST_HUNT: begin
            if (bit_in) begin
              if (zero_run >= 6'(MIN_PREAMBLE)) begin
                state    <= ST_SYNC;
                sync_cnt <= 4'd1;
              end
              zero_run <= '0;
            end else if (zero_run != 6'h3F) begin
              zero_run <= zero_run + 6'd1;
            end
          end
          ST_SYNC: begin
            if (bit_in != sync_bit) begin
              // a mismatching 0 may already be the first bit of a new preamble
              state    <= ST_HUNT;
              zero_run <= {5'd0, ~bit_in};
            end else if (sync_cnt == 4'd15) begin
              state   <= ST_LEN;
              bit_cnt <= '0;
            end else begin
              sync_cnt <= sync_cnt + 4'd1;
            end
          end
          default: begin
            shreg   <= byte_next[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_data  <= byte_next;
              byte_valid <= 1'b1;
              case (state)
                ST_LEN: begin
                  frame_start <= 1'b1;
                  len_rem     <= byte_next - 8'd1;
                  if (byte_next < 8'(LEN_MIN)) begin
                    frame_end <= 1'b1;
                    frame_err <= 1'b1;
                    crc_ok    <= 1'b0;
                    state     <= ST_HUNT;
                    zero_run  <= '0;
                  end else begin
                    state <= ST_DATA;
                  end
                end
                ST_DATA: begin
                  len_rem <= len_rem - 8'd1;
                  if (len_rem == 8'd1) begin
                    state      <= ST_CRC;
                    crc_second <= 1'b0;
                  end
                end
                default: begin
                  crc_second <= 1'b1;
                  if (crc_second) begin
                    frame_end <= 1'b1;
                    frame_err <= 1'b0;
                    crc_ok    <= (crc_final == 16'h0000);
                    state     <= ST_HUNT;
                    zero_run  <= '0;
                  end
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_felica_deframer.sv
// Scoreboard bench for felica_deframer: directed frames, expected events queued
// at stimulus time and popped by an independent output monitor.
module tb_felica_deframer;

  typedef struct packed {
    logic       bv;
    logic [7:0] data;
    logic       fs;
    logic       fe;
    logic       ok_care;
    logic       ok;
    logic       err;
  } ev_t;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       bit_valid;
  logic       bit_in;
  logic       carrier_lost;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_start;
  logic       frame_end;
  logic       crc_ok;
  logic       frame_err;

  ev_t exp_q[$];
  ev_t mon_e;
  logic mon_good;
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  felica_deframer dut (
    .ck_1356meg   (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .carrier_lost (carrier_lost),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .crc_ok       (crc_ok),
    .frame_err    (frame_err)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && (byte_valid || frame_end)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got bv=%0b data=%02h fs=%0b fe=%0b ok=%0b err=%0b, none expected",
                 byte_valid, byte_data, frame_start, frame_end, crc_ok, frame_err);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_good = (byte_valid === mon_e.bv) && (frame_start === mon_e.fs) && (frame_end === mon_e.fe);
        if (mon_e.bv && byte_data !== mon_e.data) mon_good = 1'b0;
        if (mon_e.fe && frame_err !== mon_e.err) mon_good = 1'b0;
        if (mon_e.fe && mon_e.ok_care && crc_ok !== mon_e.ok) mon_good = 1'b0;
        if (!mon_good) begin
          n_err++;
          $display("FAIL event: got bv=%0b data=%02h fs=%0b fe=%0b ok=%0b err=%0b expected bv=%0b data=%02h fs=%0b fe=%0b ok=%0b err=%0b",
                   byte_valid, byte_data, frame_start, frame_end, crc_ok, frame_err,
                   mon_e.bv, mon_e.data, mon_e.fs, mon_e.fe, mon_e.ok, mon_e.err);
        end
      end
    end
  end

  task automatic push_ev(input logic bv, input logic [7:0] data, input logic fs,
                         input logic fe, input logic ok_care, input logic ok, input logic err);
    ev_t e;
    e = '{bv: bv, data: data, fs: fs, fe: fe, ok_care: ok_care, ok: ok, err: err};
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_sync();
    send_byte(8'hB2);
    send_byte(8'h4D);
  endtask

  // 02 00 66 62: CRC-16/0x1021 of {02,00} is 0x6662, so the remainder is 0.
  task automatic good_frame_expected();
    push_ev(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b1, 8'h62, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_good_body();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h66);
    send_byte(8'h62);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b1;
    bit_valid    = 1'b0;
    bit_in       = 1'b0;
    carrier_lost = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_byte_data",   byte_data, 8'h00);
    check("reset_byte_valid",  {7'd0, byte_valid}, 8'h00);
    check("reset_frame_start", {7'd0, frame_start}, 8'h00);
    check("reset_frame_end",   {7'd0, frame_end}, 8'h00);
    check("reset_crc_ok",      {7'd0, crc_ok}, 8'h00);
    check("reset_frame_err",   {7'd0, frame_err}, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Valid frame
    good_frame_expected();
    send_zeros(48);
    send_sync();
    send_good_body();

    // CRC error in last byte
    push_ev(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b1, 8'h63, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_zeros(48);
    send_sync();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h66);
    send_byte(8'h63);

    // Short preamble ignored, then the same frame after a proper preamble
    send_zeros(15);
    send_sync();
    send_good_body();
    good_frame_expected();
    send_zeros(20);
    send_sync();
    send_good_body();

    // Sync mismatch on the last sync bit, then a real frame
    send_zeros(20);
    send_byte(8'hB2);
    send_byte(8'h4C);
    good_frame_expected();
    send_zeros(30);
    send_sync();
    send_good_body();

    // LEN below minimum
    push_ev(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_zeros(48);
    send_sync();
    send_byte(8'h01);

    // Carrier loss after the payload byte, then recovery
    push_ev(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    send_zeros(48);
    send_sync();
    send_byte(8'h02);
    send_byte(8'h00);
    @(posedge clk); #1;
    carrier_lost = 1'b1;
    @(posedge clk); #1;
    carrier_lost = 1'b0;
    repeat (4) @(posedge clk);
    good_frame_expected();
    send_zeros(48);
    send_sync();
    send_good_body();

    // enable dropped mid-frame: silent return to HUNT, then a clean frame
    push_ev(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_zeros(48);
    send_sync();
    send_byte(8'h02);
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (2) @(posedge clk); #1;
    enable = 1'b1;
    send_byte(8'h00);
    send_byte(8'h66);
    send_byte(8'h62);
    good_frame_expected();
    send_zeros(48);
    send_sync();
    send_good_body();

    repeat (10) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_events: got %0d still pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
